// File: rtl/ps2_numeric_entry_pkg.sv
// Shared definitions for the PS/2 numeric entry block: set-2 scancodes, the
// frame receiver state encoding, and the digit decode helper.
package ps2_numeric_entry_pkg;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_D0    = 8'h45;
  localparam logic [7:0] SC_D1    = 8'h16;
  localparam logic [7:0] SC_D2    = 8'h1E;
  localparam logic [7:0] SC_D3    = 8'h26;
  localparam logic [7:0] SC_D4    = 8'h25;
  localparam logic [7:0] SC_D5    = 8'h2E;
  localparam logic [7:0] SC_D6    = 8'h36;
  localparam logic [7:0] SC_D7    = 8'h3D;
  localparam logic [7:0] SC_D8    = 8'h3E;
  localparam logic [7:0] SC_D9    = 8'h46;

  // Bit 4 flags a digit key; bits 3:0 carry its value.
  function automatic logic [4:0] digit_decode(input logic [7:0] code);
    case (code)
      SC_D0:   return 5'h10;
      SC_D1:   return 5'h11;
      SC_D2:   return 5'h12;
      SC_D3:   return 5'h13;
      SC_D4:   return 5'h14;
      SC_D5:   return 5'h15;
      SC_D6:   return 5'h16;
      SC_D7:   return 5'h17;
      SC_D8:   return 5'h18;
      SC_D9:   return 5'h19;
      default: return 5'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_numeric_entry_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge detect, frame FSM,
// timeout and optional odd-parity check (enabled by defining PS2_PARITY_CHECK_EN).
module ps2_numeric_entry_frame_rx
  import ps2_numeric_entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_strobe_o,
  output logic       frame_err_o,
  output rx_state_e  state_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    ps2_clk_sync_q;
  logic [1:0]    ps2_data_sync_q;
  rx_state_e     state_q;
  logic [3:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic [TW-1:0] tmo_q;
  logic          byte_strobe_q;
  logic          frame_err_q;
  logic          fall;
  logic          data_bit;
  logic          frame_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q;
`endif

  always_comb begin
    fall     = ps2_clk_sync_q[2] & ~ps2_clk_sync_q[1];
    data_bit = ps2_data_sync_q[1];
`ifdef PS2_PARITY_CHECK_EN
    // par_q holds the XOR of the 8 data bits and the parity bit: must be odd.
    frame_ok = data_bit & par_q;
`else
    frame_ok = data_bit;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps2_clk_sync_q  <= 3'b111;
      ps2_data_sync_q <= 2'b11;
      state_q         <= RX_IDLE;
      bitcnt_q        <= 4'd0;
      shift_q         <= 8'd0;
      tmo_q           <= '0;
      byte_strobe_q   <= 1'b0;
      frame_err_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q           <= 1'b0;
`endif
    end else begin
      ps2_clk_sync_q  <= {ps2_clk_sync_q[1:0], ps2_clk_i};
      ps2_data_sync_q <= {ps2_data_sync_q[0], ps2_data_i};
      byte_strobe_q   <= 1'b0;
      frame_err_q     <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          tmo_q <= '0;
          if (fall && !data_bit) begin
            state_q  <= RX_RECV;
            bitcnt_q <= 4'd0;
`ifdef PS2_PARITY_CHECK_EN
            par_q    <= 1'b0;
`endif
          end
        end
        RX_RECV: begin
          if (fall) begin
            tmo_q <= '0;
            if (bitcnt_q < 4'd9) begin
              if (bitcnt_q < 4'd8) shift_q <= {data_bit, shift_q[7:1]};
`ifdef PS2_PARITY_CHECK_EN
              par_q <= par_q ^ data_bit;
`endif
              bitcnt_q <= bitcnt_q + 4'd1;
            end else begin
              state_q       <= RX_IDLE;
              byte_strobe_q <= frame_ok;
              frame_err_q   <= ~frame_ok;
            end
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= RX_IDLE;
            frame_err_q <= 1'b1;
            tmo_q       <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_o        = shift_q;
  assign byte_strobe_o = byte_strobe_q;
  assign frame_err_o   = frame_err_q;
  assign state_o       = state_q;

endmodule

// File: rtl/ps2_numeric_entry.sv
// PS/2 keypad front end: decodes set-2 scancodes into a decimal entry and commits it on Enter.
// Optional odd-parity frame checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_numeric_entry
  import ps2_numeric_entry_pkg::*;
#(
  parameter int DATA_W         = 14,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ps2_clk_i,
  input  logic              ps2_data_i,
  output logic [DATA_W-1:0] value_o,
  output logic              value_valid_o,
  output logic [DATA_W-1:0] entry_o,
  output logic              frame_err_o,
  output rx_state_e         rx_state_o,
  output logic [1:0]        flags_o
);

  localparam int CW = DATA_W + 4;
  localparam logic [CW-1:0] MAX_VAL = CW'({DATA_W{1'b1}});

  logic [7:0]        rx_byte;
  logic              rx_strobe;
  logic [DATA_W-1:0] entry_q;
  logic [DATA_W-1:0] value_q;
  logic              value_valid_q;
  logic              brk_q;
  logic              ext_q;
  logic [4:0]        dig;
  logic [CW-1:0]     entry_cand;
  logic [DATA_W-1:0] entry_div10;

  ps2_numeric_entry_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .byte_o       (rx_byte),
    .byte_strobe_o(rx_strobe),
    .frame_err_o  (frame_err_o),
    .state_o      (rx_state_o)
  );

  always_comb begin
    dig         = digit_decode(rx_byte);
    entry_cand  = (CW'(entry_q) << 3) + (CW'(entry_q) << 1) + CW'(dig[3:0]);
    entry_div10 = entry_q / DATA_W'(10);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q       <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
    end else begin
      value_valid_q <= 1'b0;
      if (rx_strobe) begin
        if (brk_q) begin
          // Byte after F0 is the released key: swallow it.
          brk_q <= 1'b0;
          ext_q <= 1'b0;
        end else if (rx_byte == SC_BREAK) begin
          brk_q <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          if (dig[4]) begin
            if (entry_cand <= MAX_VAL) entry_q <= entry_cand[DATA_W-1:0];
          end else begin
            case (rx_byte)
              SC_ENTER: begin
                value_q       <= entry_q;
                value_valid_q <= 1'b1;
                entry_q       <= '0;
              end
              SC_BKSP: entry_q <= entry_div10;
              SC_ESC:  entry_q <= '0;
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign value_o       = value_q;
  assign value_valid_o = value_valid_q;
  assign entry_o       = entry_q;
  assign flags_o       = {brk_q, ext_q};

endmodule
